max_pool_backward: RTL and testbench

Streaming 2-D max-pool block with an argmax-routed backward pass. It sits between the previous layer and `max_pool_layer`'s consumer.
- **Forward:** accepts an input feature map in raster order, emits the pooled map in raster order, and records the argmax position of every window.
- **Backward:** accepts the output-gradient map, then emits the full input-gradient map in raster order. Each window's gradient goes to its recorded argmax; every other position gets zero.

---
 rtl/max_pool_backward_if.sv | 31 +++
 rtl/max_pool_backward.sv | 177 +++++++++++++++++
 tb/tb_max_pool_backward.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/max_pool_backward_if.sv
// Stream bundle for max_pool_backward: forward pixels, pooled output,
// incoming output-gradients and emitted input-gradients.
interface max_pool_backward_if #(
  parameter int unsigned WIDTH = 16
);
  logic             fwd_valid;
  logic             fwd_ready;
  logic [WIDTH-1:0] fwd_data;
  logic             pool_valid;
  logic             pool_ready;
  logic [WIDTH-1:0] pool_data;
  logic             grad_in_valid;
  logic             grad_in_ready;
  logic [WIDTH-1:0] grad_in_data;
  logic             grad_out_valid;
  logic             grad_out_ready;
  logic [WIDTH-1:0] grad_out_data;
  logic             idx_valid;

  modport master (
    output fwd_valid, fwd_data, pool_ready, grad_in_valid, grad_in_data, grad_out_ready,
    input  fwd_ready, pool_valid, pool_data, grad_in_ready, grad_out_valid, grad_out_data,
           idx_valid
  );

  modport slave (
    input  fwd_valid, fwd_data, pool_ready, grad_in_valid, grad_in_data, grad_out_ready,
    output fwd_ready, pool_valid, pool_data, grad_in_ready, grad_out_valid, grad_out_data,
           idx_valid
  );
endinterface

// File: rtl/max_pool_backward.sv
// Streaming non-overlapping 2-D max pool that records each window's argmax
// and routes output-gradients back to those positions on the backward pass.
module max_pool_backward #(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned STRIDE           = 2,
  parameter int unsigned INPUT_DIM_WIDTH  = 4,
  parameter int unsigned INPUT_DIM_HEIGHT = 4
) (
  input logic                clk,
  input logic                rst_n,
  max_pool_backward_if.slave bus_io
);

  localparam int unsigned OUTPUT_DIM_WIDTH  = INPUT_DIM_WIDTH / STRIDE;
  localparam int unsigned OUTPUT_DIM_HEIGHT = INPUT_DIM_HEIGHT / STRIDE;
  localparam int unsigned IW    = ($clog2(STRIDE*STRIDE) > 1) ? $clog2(STRIDE*STRIDE) : 1;
  localparam int unsigned RW    = ($clog2(INPUT_DIM_HEIGHT) > 1) ? $clog2(INPUT_DIM_HEIGHT) : 1;
  localparam int unsigned CW    = ($clog2(INPUT_DIM_WIDTH) > 1) ? $clog2(INPUT_DIM_WIDTH) : 1;
  localparam int unsigned OCW   = ($clog2(OUTPUT_DIM_WIDTH) > 1) ? $clog2(OUTPUT_DIM_WIDTH) : 1;
  localparam int unsigned NCELL = OUTPUT_DIM_HEIGHT * OUTPUT_DIM_WIDTH;
  localparam int unsigned CELLW = ($clog2(NCELL) > 1) ? $clog2(NCELL) : 1;
  localparam int unsigned KLAST = STRIDE * STRIDE - 1;

  typedef enum logic [1:0] {IDLE, FWD, BWD_LOAD, BWD_EMIT} state_e;

  state_e                   state_q;
  logic [RW-1:0]            r_q;
  logic [CW-1:0]            c_q;
  logic [CELLW-1:0]         gcnt_q;
  logic                     pool_valid_q;
  logic [WIDTH-1:0]         pool_data_q;
  logic                     gov_q;
  logic [WIDTH-1:0]         god_q;
  logic                     idx_valid_q;

  logic signed [WIDTH-1:0]  max_q [OUTPUT_DIM_WIDTH];
  logic [IW-1:0]            arg_q [OUTPUT_DIM_WIDTH];
  logic [IW-1:0]            am_q  [NCELL];
  logic [WIDTH-1:0]         g_q   [NCELL];

  logic                     fwd_ready_c, grad_in_ready_c;
  logic                     fwd_fire_c, grad_fire_c, out_fire_c;
  logic                     last_col_c, last_pix_c, last_cell_c;
  logic [OCW-1:0]           oc_c;
  logic [IW-1:0]            k_c, nk_c;
  logic [CELLW-1:0]         cell_c, ncell_c;
  logic [RW-1:0]            nr_c;
  logic [CW-1:0]            nc_c;
  logic signed [WIDTH-1:0]  new_max_c;
  logic [IW-1:0]            new_arg_c;
  logic [WIDTH-1:0]         emit_next_c, emit_first_c;

  // Handshakes, window bookkeeping and next raster position.
  always_comb begin
    fwd_ready_c     = (state_q == IDLE || state_q == FWD) && !(pool_valid_q && !bus_io.pool_ready);
    grad_in_ready_c = (state_q == IDLE && idx_valid_q && !bus_io.fwd_valid) || (state_q == BWD_LOAD);
    fwd_fire_c      = bus_io.fwd_valid && fwd_ready_c;
    grad_fire_c     = bus_io.grad_in_valid && grad_in_ready_c;
    out_fire_c      = gov_q && bus_io.grad_out_ready;

    last_col_c  = (c_q == CW'(INPUT_DIM_WIDTH - 1));
    last_pix_c  = last_col_c && (r_q == RW'(INPUT_DIM_HEIGHT - 1));
    last_cell_c = (gcnt_q == CELLW'(NCELL - 1));

    oc_c   = OCW'(c_q / STRIDE);
    k_c    = IW'((r_q % STRIDE) * STRIDE + (c_q % STRIDE));
    cell_c = CELLW'((r_q / STRIDE) * OUTPUT_DIM_WIDTH + oc_c);

    new_max_c = max_q[oc_c];
    new_arg_c = arg_q[oc_c];
    // Strict greater-than keeps the earliest raster position on ties.
    if (k_c == '0 || $signed(bus_io.fwd_data) > max_q[oc_c]) begin
      new_max_c = $signed(bus_io.fwd_data);
      new_arg_c = k_c;
    end

    nc_c    = last_col_c ? '0 : c_q + CW'(1);
    nr_c    = last_col_c ? r_q + RW'(1) : r_q;
    ncell_c = CELLW'((nr_c / STRIDE) * OUTPUT_DIM_WIDTH + (nc_c / STRIDE));
    nk_c    = IW'((nr_c % STRIDE) * STRIDE + (nc_c % STRIDE));
    emit_next_c  = (am_q[ncell_c] == nk_c) ? g_q[ncell_c] : '0;
    // With a single cell the word being accepted is cell 0 itself.
    emit_first_c = (am_q[0] == '0) ? ((gcnt_q == '0) ? bus_io.grad_in_data : g_q[0]) : '0;
  end

  // Row buffer, argmax table and gradient buffer carry no reset.
  always_ff @(posedge clk) begin
    if (fwd_fire_c) begin
      max_q[oc_c] <= new_max_c;
      arg_q[oc_c] <= new_arg_c;
      if (k_c == IW'(KLAST)) am_q[cell_c] <= new_arg_c;
    end
    if (grad_fire_c) g_q[gcnt_q] <= bus_io.grad_in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      r_q          <= '0;
      c_q          <= '0;
      gcnt_q       <= '0;
      pool_valid_q <= 1'b0;
      pool_data_q  <= '0;
      gov_q        <= 1'b0;
      god_q        <= '0;
      idx_valid_q  <= 1'b0;
    end else begin
      if (bus_io.pool_ready) pool_valid_q <= 1'b0;
      if (fwd_fire_c && k_c == IW'(KLAST)) begin
        pool_valid_q <= 1'b1;
        pool_data_q  <= new_max_c;
      end

      case (state_q)
        IDLE: begin
          if (fwd_fire_c) begin
            state_q     <= FWD;
            idx_valid_q <= 1'b0;
            r_q         <= nr_c;
            c_q         <= nc_c;
          end
        end
        FWD: begin
          if (fwd_fire_c) begin
            if (last_pix_c) begin
              state_q     <= IDLE;
              idx_valid_q <= 1'b1;
              r_q         <= '0;
              c_q         <= '0;
            end else begin
              r_q <= nr_c;
              c_q <= nc_c;
            end
          end
        end
        BWD_EMIT: begin
          if (out_fire_c) begin
            if (last_pix_c) begin
              state_q <= IDLE;
              gov_q   <= 1'b0;
              god_q   <= '0;
              r_q     <= '0;
              c_q     <= '0;
            end else begin
              god_q <= emit_next_c;
              r_q   <= nr_c;
              c_q   <= nc_c;
            end
          end
        end
        default: ;
      endcase

      // Gradient loading is shared by IDLE (first word) and BWD_LOAD.
      if (grad_fire_c) begin
        if (last_cell_c) begin
          state_q <= BWD_EMIT;
          gcnt_q  <= '0;
          gov_q   <= 1'b1;
          god_q   <= emit_first_c;
        end else begin
          state_q <= BWD_LOAD;
          gcnt_q  <= gcnt_q + CELLW'(1);
        end
      end
    end
  end

  assign bus_io.fwd_ready      = fwd_ready_c;
  assign bus_io.grad_in_ready  = grad_in_ready_c;
  assign bus_io.pool_valid     = pool_valid_q;
  assign bus_io.pool_data      = pool_data_q;
  assign bus_io.grad_out_valid = gov_q;
  assign bus_io.grad_out_data  = god_q;
  assign bus_io.idx_valid      = idx_valid_q;

endmodule

// File: tb/tb_max_pool_backward.sv
// Scoreboard bench for max_pool_backward (4x4 input, stride 2): directed
// vectors push expected pool/gradient words; a monitor pops and compares.
module tb_max_pool_backward;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  max_pool_backward_if #(.WIDTH(W)) bus ();

  max_pool_backward #(
    .WIDTH(W), .STRIDE(2), .INPUT_DIM_WIDTH(4), .INPUT_DIM_HEIGHT(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  int exp_pool[$];
  int exp_go[$];
  int n_go    = 0;
  int fwd_acc = 0;
  bit tog_pool = 1'b0;
  bit tog_go   = 1'b0;
  bit fwd_done = 1'b0;

  int px [3][16] = '{'{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 6},
                     '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5},
                     '{-3, -1, 10, 20, -2, -4, 30, 40, 7, -8, 0, 0, 7, 9, -1, 0}};
  int pool_e [3][4] = '{'{6, 8, 9, 6}, '{5, 5, 5, 5}, '{-1, 40, 9, 0}};
  int gr     [3][4] = '{'{8, 4, 6, 3}, '{1, 2, 3, 4}, '{11, 12, 13, 14}};
  int go_e  [3][16] = '{'{0, 0, 0, 0, 0, 8, 0, 4, 6, 0, 0, 0, 0, 0, 0, 3},
                        '{1, 0, 2, 0, 0, 0, 0, 0, 3, 0, 4, 0, 0, 0, 0, 0},
                        '{0, 11, 0, 0, 0, 0, 0, 12, 0, 0, 14, 0, 0, 13, 0, 0}};

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got timeout/unexpected word, expected none", name);
  endtask

  // Scoreboard monitor: a transfer happens on the posedge after this sample.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.pool_valid && bus.pool_ready) begin
      if (exp_pool.size() == 0) fail_now("pool_extra");
      else chk("pool_data", int'($signed(bus.pool_data)), exp_pool.pop_front());
    end
    if (rst_n && bus.grad_out_valid && bus.grad_out_ready) begin
      n_go++;
      if (exp_go.size() == 0) fail_now("grad_out_extra");
      else chk("grad_out_data", int'($signed(bus.grad_out_data)), exp_go.pop_front());
    end
  end

  // Ready togglers for backpressure phases.
  initial forever begin
    @(posedge clk);
    #2;
    if (tog_pool) bus.pool_ready = ~bus.pool_ready;
    if (tog_go) bus.grad_out_ready = ~bus.grad_out_ready;
  end

  task automatic send_fwd(input int d);
    bit got = 1'b0;
    int n = 0;
    bus.fwd_valid = 1'b1;
    bus.fwd_data  = W'(d);
    while (!got && n < 200) begin
      @(negedge clk);
      got = bus.fwd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.fwd_valid = 1'b0;
    if (got) fwd_acc++;
    else fail_now("fwd_accept_timeout");
  endtask

  task automatic send_grad(input int d);
    bit got = 1'b0;
    int n = 0;
    bus.grad_in_valid = 1'b1;
    bus.grad_in_data  = W'(d);
    while (!got && n < 200) begin
      @(negedge clk);
      got = bus.grad_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.grad_in_valid = 1'b0;
    if (!got) fail_now("grad_accept_timeout");
  endtask

  task automatic run_fwd(input int v, input int from);
    for (int i = from; i < 16; i++) send_fwd(px[v][i]);
  endtask

  task automatic push_pool(input int v);
    for (int i = 0; i < 4; i++) exp_pool.push_back(pool_e[v][i]);
  endtask

  task automatic run_bwd(input int v, input int n_exp);
    for (int i = 0; i < n_exp; i++) exp_go.push_back(go_e[v][i]);
    for (int i = 0; i < 4; i++) send_grad(gr[v][i]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_pool.size() != 0 || exp_go.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({name, "_pool_left"}, exp_pool.size(), 0);
    chk({name, "_grad_left"}, exp_go.size(), 0);
  endtask

  initial begin
    int n;
    int base;
    rst_n = 1'b0;
    bus.fwd_valid = 1'b0;      bus.fwd_data = '0;
    bus.grad_in_valid = 1'b1;  bus.grad_in_data = W'(7);
    bus.pool_ready = 1'b1;     bus.grad_out_ready = 1'b1;

    // Reset values, with a stray gradient already offered.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pool_valid", int'(bus.pool_valid), 0);
    chk("rst_grad_out_valid", int'(bus.grad_out_valid), 0);
    chk("rst_pool_data", int'(bus.pool_data), 0);
    chk("rst_grad_out_data", int'(bus.grad_out_data), 0);
    chk("rst_idx_valid", int'(bus.idx_valid), 0);
    chk("rst_fwd_ready", int'(bus.fwd_ready), 1);
    chk("rst_grad_in_ready", int'(bus.grad_in_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("grad_in_ready_no_idx", int'(bus.grad_in_ready), 0);
    end
    @(posedge clk); #1 bus.grad_in_valid = 1'b0;

    // Nominal pass, backward with toggling grad_out_ready.
    push_pool(0);
    run_fwd(0, 0);
    wait_drain("fwd0");
    @(negedge clk);
    chk("idx_valid_after_fwd", int'(bus.idx_valid), 1);
    @(posedge clk); #1 tog_go = 1'b1;
    run_bwd(0, 16);
    wait_drain("bwd0");
    tog_go = 1'b0;
    bus.grad_out_ready = 1'b1;
    @(negedge clk);
    chk("grad_out_valid_drop", int'(bus.grad_out_valid), 0);
    chk("idx_valid_kept", int'(bus.idx_valid), 1);

    // Ties: every pixel equal.
    @(posedge clk); #1;
    push_pool(1);
    run_fwd(1, 0);
    wait_drain("fwd1");
    run_bwd(1, 16);
    wait_drain("bwd1");

    // Forward beats gradient when both are offered in IDLE.
    push_pool(0);
    bus.fwd_valid = 1'b1;      bus.fwd_data = W'(px[0][0]);
    bus.grad_in_valid = 1'b1;  bus.grad_in_data = W'(99);
    @(negedge clk);
    chk("prio_grad_in_ready", int'(bus.grad_in_ready), 0);
    chk("prio_fwd_ready", int'(bus.fwd_ready), 1);
    @(posedge clk); #1;
    bus.fwd_valid = 1'b0;
    bus.grad_in_valid = 1'b0;
    @(negedge clk);
    chk("prio_idx_cleared", int'(bus.idx_valid), 0);
    @(posedge clk); #1;
    run_fwd(0, 1);
    wait_drain("fwd_prio");

    // Negatives with pool_ready held low: stall after first window.
    bus.pool_ready = 1'b0;
    push_pool(2);
    fwd_acc  = 0;
    fwd_done = 1'b0;
    fork
      begin run_fwd(2, 0); fwd_done = 1'b1; end
    join_none
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("bp_pixels_accepted", fwd_acc, 6);
    chk("bp_fwd_ready", int'(bus.fwd_ready), 0);
    chk("bp_pool_valid", int'(bus.pool_valid), 1);
    chk("bp_pool_data", int'($signed(bus.pool_data)), -1);
    @(posedge clk); #1 tog_pool = 1'b1;
    n = 0;
    while (!fwd_done && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (!fwd_done) fail_now("bp_fwd_done_timeout");
    wait_drain("fwd2");
    tog_pool = 1'b0;
    bus.pool_ready = 1'b1;

    // Backward on negatives, reset after five emitted words.
    base = n_go;
    run_bwd(2, 5);
    n = 0;
    while (n_go < base + 5 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("emit_five_words", n_go - base, 5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.grad_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_grad_out_valid", int'(bus.grad_out_valid), 0);
    chk("midrst_idx_valid", int'(bus.idx_valid), 0);
    chk("midrst_grad_in_ready", int'(bus.grad_in_ready), 0);
    chk("midrst_fwd_ready", int'(bus.fwd_ready), 1);
    chk("midrst_grad_left", exp_go.size(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
